// File: rtl/axil_crossbar_pkg.sv
// rtl/axil_crossbar_pkg.sv - shared response codes and decode helpers for the crossbar return path
// Purpose: AXI-Lite response codes and one-hot to index conversion.
package axil_crossbar_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned DEC_MAX_W = 64;

    // Lowest set bit below ns wins; anything else (only bit ns set, or all zero) maps to ns.
    function automatic int unsigned onehot_to_index(input logic [DEC_MAX_W-1:0] dec,
                                                    input int unsigned ns);
        int unsigned idx;
        logic        found;
        idx   = ns;
        found = 1'b0;
        for (int unsigned i = 0; i < DEC_MAX_W; i++) begin
            if (!found && (i < ns) && dec[i]) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/decode_order_fifo.sv
// rtl/decode_order_fifo.sv - in-order queue of encoded slave indices
// Purpose: stores one encoded decode index per accepted request, head read combinationally.
// Ports: clock, reset (async active-low), push_i/push_idx_i, pop_i, head_idx_o,
//        count_o (occupancy), full_o, empty_o.
module decode_order_fifo
    import axil_crossbar_pkg::*;
#(
    parameter int IW    = 4,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_i,
    input  logic [IW-1:0] push_idx_i,
    input  logic          pop_i,
    output logic [IW-1:0] head_idx_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [IW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_idx_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry contents need no reset: an empty queue never exposes them.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_idx_i;
        end
    end

endmodule

// File: rtl/response_collector.sv
// rtl/response_collector.sv - in-order return-path steering for the crossbar
// Purpose: queues the decode of every accepted request and returns slave responses
//          to the master in request order; unmapped requests get a local DECERR.
// Ports: clock, reset (async active-low); i_valid/i_decode/o_stall (request side);
//        s_resp_valid/s_resp_ready/s_resp_data/s_resp_code (per slave);
//        m_valid/m_ready/m_data/m_resp (master side, registered).
module response_collector
    import axil_crossbar_pkg::*;
#(
    parameter int NS              = 8,
    parameter int DW              = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_stall,
    input  logic [NS:0]      i_decode,
    input  logic [NS-1:0]    s_resp_valid,
    output logic [NS-1:0]    s_resp_ready,
    input  logic [NS*DW-1:0] s_resp_data,
    input  logic [2*NS-1:0]  s_resp_code,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data,
    output logic [1:0]       m_resp
);

    localparam int IW = $clog2(NS + 1);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [IW-1:0] push_idx;
    logic [IW-1:0] head_idx;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          out_free;
    logic [NS-1:0] ready_v;
    logic [DW-1:0] ld_data;
    logic [1:0]    ld_resp;

    logic          m_valid_q, m_valid_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic [1:0]    m_resp_q, m_resp_d;

    assign push_idx = IW'(onehot_to_index(DEC_MAX_W'(i_decode), NS));

    decode_order_fifo #(
        .IW    (IW),
        .DEPTH (MAX_OUTSTANDING)
    ) u_order_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_i     (i_valid && !fifo_full),
        .push_idx_i (push_idx),
        .pop_i      (pop),
        .head_idx_o (head_idx),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Stall comes from the registered count alone, so a same-cycle pop cannot release it.
    assign o_stall = (fifo_count == CW'(MAX_OUTSTANDING));

    assign out_free = !m_valid_q || m_ready;

    always_comb begin
        ready_v = '0;
        pop     = 1'b0;
        ld_data = '0;
        ld_resp = RESP_OKAY;
        if (!fifo_empty) begin
            if (head_idx == IW'(NS)) begin
                if (out_free) begin
                    pop     = 1'b1;
                    ld_resp = RESP_DECERR;
                end
            end else begin
                for (int k = 0; k < NS; k++) begin
                    if (head_idx == IW'(k)) begin
                        ready_v[k] = out_free;
                        if (out_free && s_resp_valid[k]) begin
                            pop     = 1'b1;
                            ld_data = s_resp_data[k*DW +: DW];
                            ld_resp = s_resp_code[2*k +: 2];
                        end
                    end
                end
            end
        end
    end

    assign s_resp_ready = ready_v;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_resp_d  = m_resp_q;
        if (pop) begin
            m_valid_d = 1'b1;
            m_data_d  = ld_data;
            m_resp_d  = ld_resp;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_resp_q  <= RESP_OKAY;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_resp_q  <= m_resp_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_resp  = m_resp_q;

endmodule
